// File: rtl/mips_pkg.sv
// Shared constants for the fetch path: data width, opcode field position and the halt opcode.
package mips_pkg;

    localparam int XLEN = 32;
    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam logic [5:0] OP_HALT = 6'b111111;

    function automatic logic is_halt(input logic [OP_HI-OP_LO:0] op);
        return (op == OP_HALT);
    endfunction

endpackage

// File: rtl/inst_prefetch_fifo.sv
// prefetch_fifo: synchronous FIFO with flush; the head word is visible combinationally and reads zero when empty.
module prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int AW = CW - 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic do_push;
    logic do_pop;

    assign empty   = (count == {CW{1'b0}});
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full buffer is legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? {WIDTH{1'b0}} : mem[rptr];

    // Pointer and occupancy update; flush and reset empty the buffer.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= {AW{1'b0}};
            rptr  <= {AW{1'b0}};
            count <= {CW{1'b0}};
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetch: credit-limited fetch into a small buffer with redirect flush and in-order
// discard of stale responses. Halt-stop behaviour is enabled by INST_PREFETCH_HALT_STOP_EN.
module inst_prefetch
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = mips_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            out_valid,
    output logic [XLEN-1:0] out_ir,
    output logic [XLEN-1:0] out_npc,
    input  logic            out_ready,
    output logic            halted
);
    localparam int CW = $clog2(DEPTH) + 1;
    // Discards can pile up across back-to-back redirects, so give the counter headroom.
    localparam int DW = CW + 8;

    logic [XLEN-1:0] pc, pc_next, resp_pc, resp_pc_next, resp_npc;
    logic [CW-1:0]   outstanding, outstanding_next, out_after, fifo_count;
    logic [DW-1:0]   discard, discard_next, disc_after;
    logic            halt_flag, halt_next;
    logic            grant, accept, drop, pop, push, halt_push, fifo_full, fifo_empty;
    logic [2*XLEN-1:0] fifo_rdata;

    assign imem_req  = !rst && !redirect && !halt_flag &&
                       (({1'b0, outstanding} + {1'b0, fifo_count}) < (CW+1)'(DEPTH));
    assign imem_addr = pc;
    assign grant     = imem_req && imem_gnt;
    assign accept    = imem_rvalid && (discard == {DW{1'b0}});
    assign drop      = imem_rvalid && (discard != {DW{1'b0}});
    assign pop       = !fifo_empty && out_ready;
    assign push      = accept && !redirect && (!fifo_full || pop);
    assign resp_npc  = resp_pc + XLEN'(1);

`ifdef INST_PREFETCH_HALT_STOP_EN
    assign halt_push = accept && !redirect && is_halt(imem_rdata[OP_HI:OP_LO]);
    assign halted    = halt_flag;
`else
    assign halt_push = 1'b0;
    assign halted    = 1'b0;
`endif

    prefetch_fifo #(.DEPTH(DEPTH), .WIDTH(2*XLEN), .CW(CW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({imem_rdata, resp_npc}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign out_ir    = fifo_rdata[2*XLEN-1:XLEN];
    assign out_npc   = fifo_rdata[XLEN-1:0];

    // Next fetch/response pointers, credit, discard and halt bookkeeping.
    always_comb begin
        pc_next          = pc;
        resp_pc_next     = resp_pc;
        outstanding_next = outstanding;
        discard_next     = discard;
        halt_next        = halt_flag;
        out_after        = outstanding + CW'(grant) - CW'(accept);
        disc_after       = discard - DW'(drop);
        if (redirect) begin
            pc_next          = redirect_pc;
            resp_pc_next     = redirect_pc;
            outstanding_next = {CW{1'b0}};
            halt_next        = 1'b0;
            // Everything still in flight is stale; a response arriving now is already one of them.
            if (imem_rvalid && ((discard != {DW{1'b0}}) || (outstanding != {CW{1'b0}}))) begin
                discard_next = discard + DW'(outstanding) - DW'(1);
            end else begin
                discard_next = discard + DW'(outstanding);
            end
        end else begin
            if (grant) pc_next = pc + XLEN'(1);
            else       pc_next = pc;
            if (accept) resp_pc_next = resp_npc;
            else        resp_pc_next = resp_pc;
            if (halt_push) begin
                outstanding_next = {CW{1'b0}};
                discard_next     = disc_after + DW'(out_after);
                halt_next        = 1'b1;
            end else begin
                outstanding_next = out_after;
                discard_next     = disc_after;
                halt_next        = halt_flag;
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= {XLEN{1'b0}};
            resp_pc     <= {XLEN{1'b0}};
            outstanding <= {CW{1'b0}};
            discard     <= {DW{1'b0}};
            halt_flag   <= 1'b0;
        end else begin
            pc          <= pc_next;
            resp_pc     <= resp_pc_next;
            outstanding <= outstanding_next;
            discard     <= discard_next;
            halt_flag   <= halt_next;
        end
    end

endmodule

// File: tb/tb_inst_prefetch.sv
// Self-checking bench for inst_prefetch: directed scenarios plus randomized traffic against a
// stream-level reference model (fetch/consume address streams and an in-order memory queue).
module tb_inst_prefetch;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic clk = 1'b0;
    logic rst, redirect, imem_req, imem_gnt, imem_rvalid, out_valid, out_ready, halted;
    logic [XLEN-1:0] redirect_pc, imem_addr, imem_rdata, out_ir, out_npc;

    always #5 clk = ~clk;

    inst_prefetch #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .out_valid(out_valid), .out_ir(out_ir), .out_npc(out_npc),
        .out_ready(out_ready), .halted(halted)
    );

    typedef struct { logic [31:0] addr; int due; } req_t;
    req_t memq[$];

    int nchk = 0;
    int nfail = 0;
    int cyc = 0;
    logic [31:0] fetch_addr = 32'd0;
    logic [31:0] consume_addr = 32'd0;
    logic [31:0] halt_addr = 32'hDEAD_0000;
    logic chk_req = 1'b1;
    logic prev_valid = 1'b0, prev_ready = 1'b0, prev_redir = 1'b0, prev_rst = 1'b0;
    logic [31:0] prev_ir = 32'd0, prev_npc = 32'd0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        if (a == halt_addr) return 32'hFC00_0000;
        h = a * 32'h9E37_79B1 + 32'h0123_4567;
        return {1'b0, h[30:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, play the memory, check outputs, then advance the model.
    task automatic cycle(input logic rs, input logic rd, input logic [31:0] rpc,
                         input logic rdy, input logic gnt, input int lat);
        logic g, c;
        logic [31:0] a;
        rst = rs; redirect = rd; redirect_pc = rpc; out_ready = rdy; imem_gnt = gnt;
        if (rs) begin
            memq.delete();
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
        end else if (memq.size() > 0 && memq[0].due <= cyc + 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(memq[0].addr);
            void'(memq.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        if (prev_rst) begin
            check1("rst_valid", out_valid, 1'b0);
            check("rst_ir", out_ir, 32'd0);
            check("rst_npc", out_npc, 32'd0);
            check1("rst_halted", halted, 1'b0);
        end
        if (prev_redir) check1("flush_valid", out_valid, 1'b0);
        if (prev_valid && !prev_ready && !prev_redir && !prev_rst) begin
            check("hold_ir", out_ir, prev_ir);
            check("hold_npc", out_npc, prev_npc);
        end
        if (chk_req) begin
            check1("imem_req", imem_req, !rs && !rd && ((fetch_addr - consume_addr) < 32'(DEPTH)));
            check1("halted", halted, 1'b0);
        end
        g = imem_req && gnt;
        c = out_valid && rdy;
        a = imem_addr;
        if (g) check("imem_addr", a, fetch_addr);
        if (c && !rd && !rs) begin
            check("out_ir", out_ir, mem_word(consume_addr));
            check("out_npc", out_npc, consume_addr + 32'd1);
        end
        prev_valid = out_valid; prev_ready = rdy; prev_ir = out_ir; prev_npc = out_npc;
        prev_redir = rd; prev_rst = rs;
        @(posedge clk);
        cyc++;
        if (rs) begin
            fetch_addr = 32'd0;
            consume_addr = 32'd0;
        end else if (rd) begin
            fetch_addr = rpc;
            consume_addr = rpc;
        end else begin
            if (g) begin
                memq.push_back('{a, cyc + lat});
                fetch_addr = fetch_addr + 32'd1;
            end
            if (c) consume_addr = consume_addr + 32'd1;
        end
        #1;
    endtask

    task automatic run(input int n, input logic rdy, input logic gnt, input int lat);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, rdy, gnt, lat);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1);
        cycle(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1);
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = 32'd0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Back-to-back fetch with 1-cycle memory and a always-ready decoder.
        run(12, 1'b1, 1'b1, 1);
        check("stream_consumed", consume_addr, 32'd10);
        check("stream_fetched", fetch_addr, 32'd12);

        // Decoder stalled: credit limit, then one pop releases one grant.
        do_reset();
        run(10, 1'b0, 1'b1, 1);
        check("stall_grants", fetch_addr, 32'd4);
        check1("stall_req_low", imem_req, 1'b0);
        run(1, 1'b1, 1'b1, 1);
        run(6, 1'b0, 1'b1, 1);
        check("one_pop_grant", fetch_addr, 32'd5);
        check("one_pop_consumed", consume_addr, 32'd1);

        // Redirect with three requests in flight.
        do_reset();
        run(3, 1'b1, 1'b1, 6);
        cycle(1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 1);
        run(12, 1'b1, 1'b1, 1);
        check1("redir_progress", consume_addr >= 32'h44, 1'b1);

        // Redirect while a word returns and the head is being consumed.
        do_reset();
        run(5, 1'b1, 1'b1, 1);
        check1("redir_rvalid_setup", imem_rvalid && out_valid, 1'b1);
        cycle(1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 1);
        run(8, 1'b1, 1'b1, 1);

        // Reset with two outstanding and two buffered.
        do_reset();
        run(2, 1'b0, 1'b1, 1);
        run(2, 1'b0, 1'b1, 5);
        cycle(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1);
        run(10, 1'b1, 1'b1, 1);

        // Halt opcode at address 5.
        do_reset();
        halt_addr = 32'd5;
`ifdef INST_PREFETCH_HALT_STOP_EN
        chk_req = 1'b0;
        run(20, 1'b1, 1'b1, 1);
        check1("halt_set", halted, 1'b1);
        check1("halt_no_req", imem_req, 1'b0);
        check("halt_consumed", consume_addr, 32'd6);
        halt_addr = 32'hDEAD_0000;
        chk_req = 1'b1;
        cycle(1'b0, 1'b1, 32'd0, 1'b1, 1'b1, 1);
        check1("halt_cleared", halted, 1'b0);
        run(8, 1'b1, 1'b1, 1);
`else
        run(15, 1'b1, 1'b1, 1);
        check1("halt_ignored", consume_addr >= 32'd6, 1'b1);
        halt_addr = 32'hDEAD_0000;
`endif

        // PC wrap-around.
        cycle(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1, 1);
        run(10, 1'b1, 1'b1, 1);
        check1("wrap", consume_addr < 32'h10, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            cycle(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 29) == 0),
                  32'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) != 0), $urandom_range(1, 4));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule
